pipelined_multiplier_param: RTL and testbench

Parametrised successor of the fixed 4x4 pipelined shift-add multiplier. It computes one WIDTH x WIDTH product per cycle through a WIDTH-stage shift-add pipeline, one partial-product bit per stage. It adds per-transaction signed/unsigned mode, a tag carried alongside each operand pair, and full valid/ready backpressure with a global pipeline stall. It sits between operand producers and result consumers in the datapath, replacing the fixed-width version.

---
 rtl/pipelined_multiplier_param.sv | 88 ++++++++
 tb/tb_pipelined_multiplier_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier_param.sv
// WIDTH x WIDTH shift-add multiplier: one partial-product bit per stage, one result per cycle,
// per-operation signed/unsigned mode and tag, valid/ready handshake with a global stall.
module pipelined_multiplier_param #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 data_rdy,
  output logic                 data_ack,
  input  logic [WIDTH-1:0]     mult1,
  input  logic [WIDTH-1:0]     mult2,
  input  logic                 sgn,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 res_rdy,
  input  logic                 res_ack,
  output logic [2*WIDTH-1:0]   res,
  output logic [TAG_W-1:0]     tag_out
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 1;

  // mcand is kept pre-shifted and mplier pre-shifted so every stage looks at fixed bit positions
  typedef struct packed {
    logic             valid;
    logic             neg;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
  } stage_t;

  stage_t st_q [WIDTH];
  stage_t st_in;

  logic             stall;
  logic [MW-1:0]    mcand_ext;
  logic [MW-1:0]    mcand_mag;
  logic [WIDTH-1:0] mplier_mag;
  logic [PW-1:0]    res_next;

  assign stall    = res_rdy & ~res_ack;
  assign data_ack = ~stall;

  function automatic stage_t step(input stage_t p);
    stage_t n;
    n        = p;
    n.acc    = p.acc + (p.mplier[1] ? (p.mcand << 1) : '0);
    n.mcand  = p.mcand << 1;
    n.mplier = p.mplier >> 1;
    return n;
  endfunction

  // Magnitude conversion uses a sign-extended extra bit so that -2^(WIDTH-1) stays exact
  always_comb begin
    st_in      = '0;
    mcand_ext  = {sgn & mult1[WIDTH-1], mult1};
    mcand_mag  = (sgn & mult1[WIDTH-1]) ? -mcand_ext : mcand_ext;
    mplier_mag = (sgn & mult2[WIDTH-1]) ? -mult2 : mult2;
    if (data_rdy) begin
      st_in.valid  = 1'b1;
      st_in.neg    = sgn & (mult1[WIDTH-1] ^ mult2[WIDTH-1]);
      st_in.tag    = tag_in;
      st_in.mcand  = {{(PW-MW){1'b0}}, mcand_mag};
      st_in.mplier = mplier_mag;
      st_in.acc    = mplier_mag[0] ? st_in.mcand : '0;
    end
  end

  assign res_next = st_q[WIDTH-1].neg ? -st_q[WIDTH-1].acc : st_q[WIDTH-1].acc;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < WIDTH; i++) st_q[i] <= '0;
      res_rdy <= 1'b0;
      res     <= '0;
      tag_out <= '0;
    end else if (!stall) begin
      st_q[0] <= st_in;
      for (int i = 1; i < WIDTH; i++) st_q[i] <= step(st_q[i-1]);
      res_rdy <= st_q[WIDTH-1].valid;
      res     <= res_next;
      tag_out <= st_q[WIDTH-1].tag;
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_param.sv
// Directed bench for pipelined_multiplier_param at WIDTH=4/TAG_W=2 and WIDTH=8/TAG_W=4.
module tb_pipelined_multiplier_param;

  logic clk;
  logic rstn;

  logic       d4_rdy, d4_ack, d4_sgn, r4_rdy, r4_ack;
  logic [3:0] d4_m1, d4_m2;
  logic [1:0] d4_tag, r4_tag;
  logic [7:0] r4_res;

  logic        d8_rdy, d8_ack, d8_sgn, r8_rdy, r8_ack;
  logic [7:0]  d8_m1, d8_m2;
  logic [3:0]  d8_tag, r8_tag;
  logic [15:0] r8_res;

  int check_count = 0;
  int fail_count  = 0;

  pipelined_multiplier_param #(.WIDTH(4), .TAG_W(2)) dut4 (
    .clk(clk), .rstn(rstn), .data_rdy(d4_rdy), .data_ack(d4_ack),
    .mult1(d4_m1), .mult2(d4_m2), .sgn(d4_sgn), .tag_in(d4_tag),
    .res_rdy(r4_rdy), .res_ack(r4_ack), .res(r4_res), .tag_out(r4_tag)
  );

  pipelined_multiplier_param #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rstn(rstn), .data_rdy(d8_rdy), .data_ack(d8_ack),
    .mult1(d8_m1), .mult2(d8_m2), .sgn(d8_sgn), .tag_in(d8_tag),
    .res_rdy(r8_rdy), .res_ack(r8_ack), .res(r8_res), .tag_out(r8_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [1:0] t);
    d4_rdy = 1'b1;
    d4_m1  = a;
    d4_m2  = b;
    d4_sgn = s;
    d4_tag = t;
  endtask

  // One isolated WIDTH=4 operation: no result before edge 4, result after edge 4, gone after edge 5
  task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [1:0] t, input logic [7:0] exp);
    apply_stimulus(a, b, s, t);
    tick();
    d4_rdy = 1'b0;
    repeat (3) tick();
    check_output({name, "_early"}, 32'(r4_rdy), 32'd0);
    tick();
    check_output({name, "_rdy"}, 32'(r4_rdy), 32'd1);
    check_output({name, "_res"}, 32'(r4_res), 32'(exp));
    check_output({name, "_tag"}, 32'(r4_tag), 32'(t));
    tick();
    check_output({name, "_once"}, 32'(r4_rdy), 32'd0);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic [15:0] exp);
    d8_rdy = 1'b1;
    d8_m1  = a;
    d8_m2  = b;
    d8_sgn = s;
    d8_tag = t;
    tick();
    d8_rdy = 1'b0;
    repeat (7) tick();
    check_output({name, "_early"}, 32'(r8_rdy), 32'd0);
    tick();
    check_output({name, "_rdy"}, 32'(r8_rdy), 32'd1);
    check_output({name, "_res"}, 32'(r8_res), 32'(exp));
    check_output({name, "_tag"}, 32'(r8_tag), 32'(t));
    tick();
  endtask

  // Back-to-back table: {mult1, mult2, sgn, tag, expected product}
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [1:0] t;
    logic [7:0] p;
  } op_t;

  op_t ops [16];

  initial begin
    ops[0]  = '{a: 4'd3,  b: 4'd5,  s: 1'b0, t: 2'd0, p: 8'h0F};
    ops[1]  = '{a: 4'd15, b: 4'd2,  s: 1'b0, t: 2'd1, p: 8'h1E};
    ops[2]  = '{a: 4'hF,  b: 4'hF,  s: 1'b1, t: 2'd2, p: 8'h01};
    ops[3]  = '{a: 4'd12, b: 4'd12, s: 1'b0, t: 2'd3, p: 8'h90};
    ops[4]  = '{a: 4'hC,  b: 4'h3,  s: 1'b1, t: 2'd0, p: 8'hF4};
    ops[5]  = '{a: 4'd9,  b: 4'd11, s: 1'b0, t: 2'd1, p: 8'h63};
    ops[6]  = '{a: 4'h7,  b: 4'h7,  s: 1'b1, t: 2'd2, p: 8'h31};
    ops[7]  = '{a: 4'h8,  b: 4'h1,  s: 1'b1, t: 2'd3, p: 8'hF8};
    ops[8]  = '{a: 4'd10, b: 4'd6,  s: 1'b0, t: 2'd0, p: 8'h3C};
    ops[9]  = '{a: 4'h5,  b: 4'hA,  s: 1'b1, t: 2'd1, p: 8'hE2};
    ops[10] = '{a: 4'h0,  b: 4'hF,  s: 1'b1, t: 2'd2, p: 8'h00};
    ops[11] = '{a: 4'd13, b: 4'd14, s: 1'b0, t: 2'd3, p: 8'hB6};
    ops[12] = '{a: 4'hD,  b: 4'hB,  s: 1'b1, t: 2'd0, p: 8'h0F};
    ops[13] = '{a: 4'd8,  b: 4'd15, s: 1'b0, t: 2'd1, p: 8'h78};
    ops[14] = '{a: 4'h6,  b: 4'h9,  s: 1'b1, t: 2'd2, p: 8'hD6};
    ops[15] = '{a: 4'd1,  b: 4'd1,  s: 1'b0, t: 2'd3, p: 8'h01};

    rstn   = 1'b1;
    d4_rdy = 1'b0; d4_m1 = '0; d4_m2 = '0; d4_sgn = 1'b0; d4_tag = '0; r4_ack = 1'b1;
    d8_rdy = 1'b0; d8_m1 = '0; d8_m2 = '0; d8_sgn = 1'b0; d8_tag = '0; r8_ack = 1'b1;

    $display("[TB] reset state");
    repeat (2) tick();
    check_output("rst_rdy", 32'(r4_rdy), 32'd0);
    check_output("rst_res", 32'(r4_res), 32'd0);
    check_output("rst_tag", 32'(r4_tag), 32'd0);
    rstn = 1'b0;
    #1;
    check_output("rst_ack", 32'(d4_ack), 32'd1);
    tick();

    $display("[TB] single operations, WIDTH=4");
    run4("u15x15", 4'd15, 4'd15, 1'b0, 2'd2, 8'hE1);
    run4("u0x9",   4'd0,  4'd9,  1'b0, 2'd1, 8'h00);
    run4("sm8xm8", 4'h8,  4'h8,  1'b1, 2'd3, 8'h40);
    run4("sm8x7",  4'h8,  4'h7,  1'b1, 2'd0, 8'hC8);
    run4("s7xm1",  4'h7,  4'hF,  1'b1, 2'd1, 8'hF9);
    run4("u8x8",   4'h8,  4'h8,  1'b0, 2'd2, 8'h40);
    run4("u8x7",   4'h8,  4'h7,  1'b0, 2'd3, 8'h38);
    run4("u7x15",  4'h7,  4'hF,  1'b0, 2'd0, 8'h69);

    $display("[TB] back-to-back stream");
    for (int c = 0; c < 20; c++) begin
      if (c < 16) apply_stimulus(ops[c].a, ops[c].b, ops[c].s, ops[c].t);
      else d4_rdy = 1'b0;
      tick();
      if (c == 2) check_output("b2b_early", 32'(r4_rdy), 32'd0);
      if (c >= 4) begin
        check_output($sformatf("b2b%0d_rdy", c - 4), 32'(r4_rdy), 32'd1);
        check_output($sformatf("b2b%0d_res", c - 4), 32'(r4_res), 32'(ops[c-4].p));
        check_output($sformatf("b2b%0d_tag", c - 4), 32'(r4_tag), 32'(ops[c-4].t));
      end
    end
    tick();
    check_output("b2b_drain", 32'(r4_rdy), 32'd0);

    $display("[TB] backpressure");
    apply_stimulus(4'd2, 4'd3, 1'b0, 2'd1);
    tick();
    apply_stimulus(4'd4, 4'd5, 1'b0, 2'd2);
    tick();
    apply_stimulus(4'd9, 4'd9, 1'b0, 2'd3);
    tick();
    d4_rdy = 1'b0;
    repeat (2) tick();
    check_output("bp_first_res", 32'(r4_res), 32'h06);
    r4_ack = 1'b0;
    apply_stimulus(4'd7, 4'd3, 1'b0, 2'd0);
    #1;
    check_output("bp_ack_low", 32'(d4_ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output($sformatf("bp_hold%0d_rdy", i), 32'(r4_rdy), 32'd1);
      check_output($sformatf("bp_hold%0d_res", i), 32'(r4_res), 32'h06);
      check_output($sformatf("bp_hold%0d_tag", i), 32'(r4_tag), 32'd1);
      check_output($sformatf("bp_hold%0d_ack", i), 32'(d4_ack), 32'd0);
    end
    r4_ack = 1'b1;
    tick();
    d4_rdy = 1'b0;
    check_output("bp_b_res", 32'(r4_res), 32'h14);
    check_output("bp_b_tag", 32'(r4_tag), 32'd2);
    tick();
    check_output("bp_c_res", 32'(r4_res), 32'h51);
    check_output("bp_c_tag", 32'(r4_tag), 32'd3);
    tick();
    check_output("bp_gap1", 32'(r4_rdy), 32'd0);
    tick();
    check_output("bp_gap2", 32'(r4_rdy), 32'd0);
    tick();
    check_output("bp_d_rdy", 32'(r4_rdy), 32'd1);
    check_output("bp_d_res", 32'(r4_res), 32'h15);
    check_output("bp_d_tag", 32'(r4_tag), 32'd0);
    tick();
    check_output("bp_d_once", 32'(r4_rdy), 32'd0);

    $display("[TB] reset mid-flight");
    apply_stimulus(4'd1, 4'd2, 1'b0, 2'd1);
    tick();
    apply_stimulus(4'd3, 4'd3, 1'b0, 2'd2);
    tick();
    apply_stimulus(4'd6, 4'd6, 1'b0, 2'd3);
    tick();
    d4_rdy = 1'b0;
    repeat (2) tick();
    check_output("mid_pre_res", 32'(r4_res), 32'h02);
    rstn = 1'b1;
    #1;
    check_output("mid_rst_rdy", 32'(r4_rdy), 32'd0);
    check_output("mid_rst_res", 32'(r4_res), 32'd0);
    check_output("mid_rst_tag", 32'(r4_tag), 32'd0);
    tick();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("mid_stale%0d", i), 32'(r4_rdy), 32'd0);
    end
    run4("mid_u3x5", 4'd3, 4'd5, 1'b0, 2'd1, 8'h0F);

    $display("[TB] WIDTH=8 regression");
    run8("w8_u255x255", 8'hFF, 8'hFF, 1'b0, 4'hA, 16'hFE01);
    run8("w8_sm128sq",  8'h80, 8'h80, 1'b1, 4'h5, 16'h4000);
    run8("w8_sm128x127", 8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
